// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the multiplier HI/LO issue/writeback
//               slice: request opcodes, multiplier sign modes, controller
//               state encoding and the default multiplier latency.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Request opcodes carried on req_op
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  // Multiplier sign modes (mixed modes are never driven)
  localparam logic [1:0] SIGN_SS = 2'b00;
  localparam logic [1:0] SIGN_UU = 2'b11;

  // Edges from accept to HI/LO capture: load, 32 shifts, out_en, output reg
  localparam int MULT_LATENCY_DEF = 35;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mult_lat_cnt
// Description : Loadable down-counter with a zero flag, used to time the
//               fixed multiplier latency.
// Ports       : clk, rst (async, active-high)
//               i_load / i_load_val : load the counter (priority over dec)
//               i_dec               : decrement by one
//               o_zero              : counter currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module mult_lat_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl
// Description : Issue/writeback stage around the sequential 32x32 multiplier.
//               Accepts MULT/MULTU/MADD/MADDU and MTHI/MTLO/MFHI/MFLO over a
//               valid/ready handshake, drives the multiplier operands, waits
//               MULT_LATENCY edges and captures the product into HI/LO.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_op/req_a/req_b : request channel
//               mul_a/mul_b/mul_ctrl                   : to multiplier
//               mul_lower/mul_higher                   : from multiplier
//               rd_valid/rd_data                       : MF result
//               busy, hi, lo                           : status / architectural regs
// Config      : `define MULT_HILO_MADD_EN makes MADD/MADDU accumulate into
//               {hi,lo}; otherwise they overwrite exactly like MULT/MULTU.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int CNT_W        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [4:0]  mul_ctrl,
  input  logic [31:0] mul_lower,
  input  logic [31:0] mul_higher,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MULT_LATENCY - 1);

  state_t      r_state;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_zero;
  logic [63:0] w_product;
  logic [63:0] w_next_hilo;

  assign req_ready  = (r_state == IDLE) & ~rst;
  assign w_accept   = req_valid & req_ready;
  // Multiply ops are 0,1 (MULT/MULTU) and 6,7 (MADD/MADDU)
  assign w_is_mul   = (req_op[2:1] == 2'b00) | (req_op[2:1] == 2'b11);
  assign w_cnt_load = w_accept & w_is_mul;
  assign w_cnt_dec  = (r_state == WAIT) & ~w_cnt_zero;
  assign w_product  = {mul_higher, mul_lower};

  mult_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (c_cnt_load),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

`ifdef MULT_HILO_MADD_EN
  // Remembers whether the multiply in flight is a MADD/MADDU (op bit 2)
  logic r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 1'b0;
    end else if (w_cnt_load) begin
      r_acc <= req_op[2];
    end
  end

  // 64-bit wrap-around accumulate; carry out is intentionally dropped
  assign w_next_hilo = r_acc ? ({hi, lo} + w_product) : w_product;
`else
  assign w_next_hilo = w_product;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      hi       <= '0;
      lo       <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ctrl <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                mul_a    <= req_a;
                mul_b    <= req_b;
                // Token toggle restarts mult even for repeated operands
                mul_ctrl <= {2'b00, ~mul_ctrl[2], (req_op[0] ? SIGN_UU : SIGN_SS)};
                busy     <= 1'b1;
                r_state  <= WAIT;
              end
            endcase
          end
        end
        WAIT: begin
          if (w_cnt_zero) begin
            {hi, lo} <= w_next_hilo;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_hilo_ctrl
// Description : Self-checking bench for mult_hilo_ctrl with a behavioural
//               multiplier whose product only becomes valid late in the
//               latency window, and queue-based scoreboards for HI/LO
//               captures and MF reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_ctrl;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] mul_a, mul_b;
  logic [4:0]  mul_ctrl;
  logic [31:0] mul_lower, mul_higher;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mq[$];   // expected {hi,lo} after each multiply
  logic [31:0] rq[$];   // expected MF read data
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_hilo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ctrl   (mul_ctrl),
    .mul_lower  (mul_lower),
    .mul_higher (mul_higher),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  // Behavioural multiplier: product valid only once the token has been
  // stable for 33 edges, garbage before that, so early capture is visible.
  logic        tok_q;
  int          age;
  logic [63:0] prod;
  always_comb begin
    prod = '0;
    if (mul_ctrl[1:0] == SIGN_UU)
      prod = {32'b0, mul_a} * {32'b0, mul_b};
    else
      prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_q <= 1'b0;
      age   <= 0;
    end else begin
      tok_q <= mul_ctrl[2];
      if (mul_ctrl[2] != tok_q) age <= 0;
      else if (age < 100)       age <= age + 1;
    end
  end
  assign {mul_higher, mul_lower} = (age >= 33) ? prod : 64'hBAD0BAD0_BAD0BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: busy-window length, HI/LO capture and MF read scoreboards
  logic bprev = 1'b0;
  int   bcnt  = 0;
  always @(negedge clk) begin
    if (rst) begin
      bprev = 1'b0;
      bcnt  = 0;
    end else begin
      if (busy) bcnt++;
      if (bprev && !busy) begin
        check("busy_len", 64'(bcnt), 64'd35);
        if (mq.size() == 0) check("mul_expected_pending", 0, 1);
        else                check("hilo_capture", {hi, lo}, mq.pop_front());
        bcnt = 0;
      end
      bprev = busy;
      if (rd_valid) begin
        if (rq.size() == 0) check("rd_expected_pending", 0, 1);
        else                check("rd_data", {32'b0, rd_data}, {32'b0, rq.pop_front()});
      end
    end
  end

  // Drive one request; waits (bounded) for req_ready, updates the model
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int waited);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_wait", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    case (op)
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_MFHI: rq.push_back(m_hi);
      OP_MFLO: rq.push_back(m_lo);
      default: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op[0]) p = {32'b0, a} * {32'b0, b};
        else       p = sa * sb;
`ifdef MULT_HILO_MADD_EN
        if (op[2]) p = p + {m_hi, m_lo};
`endif
        {m_hi, m_lo} = p;
        mq.push_back(p);
      end
    endcase
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int w;
    logic tok0;

    // Reset state
    #12;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy_rdv", {62'b0, busy, rd_valid}, 64'd0);
    check("rst_mul", {mul_ctrl, mul_a}, 64'd0);
    check("rst_rd_data", {32'b0, rd_data}, 64'd0);
    check("rst_ready", {63'b0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Signed MULT -3 x 5, then MFLO
    issue(OP_MULT, 32'hFFFFFFFD, 32'h5, w);
    check("mult_sign_mode", {62'b0, mul_ctrl[1:0]}, {62'b0, SIGN_SS});
    check("ready_low_busy", {63'b0, req_ready}, 64'd0);
    wait_idle();
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(OP_MFLO, 0, 0, w);

    // Unsigned MULTU max x max
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, w);
    check("multu_sign_mode", {62'b0, mul_ctrl[1:0]}, {62'b0, SIGN_UU});
    wait_idle();
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);

    // Back-to-back identical MULT 7 x 6
    tok0 = mul_ctrl[2];
    issue(OP_MULT, 32'd7, 32'd6, w);
    check("tok_toggle1", {63'b0, mul_ctrl[2]}, {63'b0, ~tok0});
    tok0 = mul_ctrl[2];
    issue(OP_MULT, 32'd7, 32'd6, w);
    check("b2b_wait", 64'(w), 64'd35);
    check("tok_toggle2", {63'b0, mul_ctrl[2]}, {63'b0, ~tok0});
    wait_idle();
    check("b2b_result", {hi, lo}, 64'h00000000_0000002A);

    // MTHI / MFHI, then MFLO held off by an active multiply
    issue(OP_MTHI, 32'h12345678, 0, w);
    issue(OP_MFHI, 0, 0, w);
    issue(OP_MULT, 32'd2, 32'd3, w);
    check("mf_stall_ready", {63'b0, req_ready}, 64'd0);
    issue(OP_MFLO, 0, 0, w);
    check("mf_stall_wait", {63'b0, (w >= 30)}, 64'd1);

    // Reset in the middle of WAIT
    issue(OP_MULT, 32'h00010000, 32'h00030000, w);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    mq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_write", {hi, lo}, 64'd0);
    issue(OP_MULT, 32'd2, 32'd3, w);
    wait_idle();
    check("post_rst_mult", {hi, lo}, 64'd6);

    // MADDU after MTLO/MTHI
    issue(OP_MTLO, 32'hFFFFFFFF, 0, w);
    issue(OP_MTHI, 32'h0, 0, w);
    issue(OP_MADDU, 32'd1, 32'd1, w);
    wait_idle();
`ifdef MULT_HILO_MADD_EN
    check("maddu", {hi, lo}, 64'h00000001_00000000);
`else
    check("maddu", {hi, lo}, 64'h00000000_00000001);
`endif

    repeat (3) @(negedge clk);
    check("rq_drained", 64'(rq.size()), 64'd0);
    check("mq_drained", 64'(mq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
